demux2_dispatch_ctrl: RTL
=========================

Name: demux2_dispatch_ctrl

Overview:
- Sequencing controller for the two-way demux datapath. It accepts a W-bit word stream over a valid/ready handshake and holds each word in a one-entry output register.
- For each word it chooses a destination and drives the demux select and data input. It then completes a per-destination valid/ready handshake with the two downstream consumers.
- Destination is chosen in one of two modes: round-robin in bursts, or by a per-word tag.
- It also keeps per-destination delivery counters for status and debug.

Parameters:
- W, 16, data width; matches the demux data width.
- BURST, 4, consecutive words sent to one destination before round-robin switches; legal range 1..255.
- CNT_W, 8, width of each delivery counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  W  upstream word.
- in_valid  in  1  upstream word valid.
- in_dest  in  1  destination tag; used only when mode=1.
- in_ready  out  1  controller can accept a word this cycle.
- mode  in  1  0 = round-robin burst, 1 = tag-directed.
- clr_cnt  in  1  synchronous clear of both counters.
- dmx_sel  out  1  demux select.
- dmx_data  out  W  demux input data.
- out_valid_0  out  1  word valid toward destination 0.
- out_valid_1  out  1  word valid toward destination 1.
- out_ready_0  in  1  destination 0 accepts.
- out_ready_1  in  1  destination 1 accepts.
- cnt_0  out  CNT_W  words delivered to destination 0.
- cnt_1  out  CNT_W  words delivered to destination 1.
- busy  out  1  output register holds an undelivered word.

Behaviour:
- Reset (rst_n low, asynchronous): outputs and state are forced as follows.
  - State = EMPTY.
  - dmx_sel = 0, dmx_data = 0.
  - out_valid_0 = 0, out_valid_1 = 0, busy = 0.
  - cnt_0 = 0, cnt_1 = 0.
  - rr_ptr = 0, burst_cnt = 0.
  - in_ready is combinational and equals 1 in EMPTY.
- Reset mid-operation: any held word is discarded and is not counted.
- FSM state EMPTY: nothing is held.
  - in_ready = 1.
  - On accept (in_valid && in_ready), load the word, go to FULL.
- FSM state FULL: a word is held.
  - in_ready = out_ready of the current destination. This gives a same-cycle pass-through slot.
  - Delivery without a new accept goes to EMPTY.
  - Delivery with a simultaneous accept loads the new word, stays FULL, and updates the destination.
- Latency: a word accepted in cycle N is presented in cycle N+1. Throughput is one word per cycle while the current destination stays ready.
- Destination decision is made at accept time and registered into dmx_sel:
  - mode=1: dest = in_dest.
  - mode=0: dest = rr_ptr. burst_cnt then increments. When it reaches BURST it becomes 0 and rr_ptr toggles. With BURST=1 the destinations alternate every word.
- rr_ptr and burst_cnt advance only on accepts made in mode=0. They are retained unchanged across mode=1 periods.
- mode is sampled only at accept. Changing mode while FULL does not alter the held word's destination.
- Output valids:
  - out_valid_0 = FULL && dmx_sel==0.
  - out_valid_1 = FULL && dmx_sel==1.
  - They are never both 1.
  - The non-selected consumer's ready is ignored.
- Idle hold: in EMPTY, dmx_data and dmx_sel keep their last values, and both valids are 0.
- Stalls: while FULL and not delivered, dmx_data and dmx_sel are stable.
- Counters:
  - cnt_x increments on out_valid_x && out_ready_x.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt has priority over an increment in the same cycle; a delivery in the clear cycle is not counted.
- busy = FULL.

Decomposition:
- Shared package holds:
  - state encoding constants ST_EMPTY and ST_FULL;
  - mode constants MODE_RR=0 and MODE_TAG=1;
  - the default data width of 16, shared with the demux.
- The existing demux2 is instantiated at the level above, fed by dmx_sel and dmx_data; it is not inside this block.
- One natural sub-module: sat_counter (parameter CNT_W, inputs inc and clr).

Test Plan:
- Reset then idle → in_ready=1, all valids 0, dmx_sel=0, counters 0; asserting rst_n low while FULL → busy=0 immediately.
- mode=0, BURST=4, both sinks ready, send 0x0001..0x0008 back-to-back → words 1-4 delivered on valid_0, words 5-8 on valid_1, one per cycle, 1-cycle latency, cnt_0=4, cnt_1=4.
- mode=1, in_dest pattern 1,0,1 with data 0xAAAA,0x5555,0xBEEF → valid_1/0xAAAA, valid_0/0x5555, valid_1/0xBEEF, rr_ptr and burst_cnt unchanged.
- Backpressure: out_ready_0=0 for 3 cycles while a word for destination 0 is held → in_ready=0, dmx_data stable, no count; out_ready_0=1 → delivered, and a simultaneous new word is accepted in the same cycle.
- Counter saturation, CNT_W=2: deliver 5 words to destination 0 → cnt_0=3; clr_cnt together with a delivery → cnt_0=0.
- Mode switch: mode=0, 2 words sent, switch to mode=1 for 3 tagged words, back to mode=0, 2 words → the final 2 words complete the first burst on destination 0, and the next word goes to destination 1.

Source files
------------

// File: rtl/demux2_dispatch_ctrl_pkg.sv
// Shared definitions for the two-way demux dispatch controller and its datapath.
package demux2_dispatch_ctrl_pkg;

  // Data width shared with the demux2 datapath.
  localparam int DMX_W = 16;

  // Output-register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Destination selection modes.
  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_TAG = 1'b1;

endpackage

// File: rtl/demux2_dispatch_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Counter register: clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/demux2_dispatch_ctrl.sv
// Dispatch controller feeding the two-way demux: accepts a word stream, holds one
// word in an output register, picks its destination (round-robin bursts or tag)
// and completes the per-destination handshake. Keeps per-destination delivery counts.
module demux2_dispatch_ctrl
  import demux2_dispatch_ctrl_pkg::*;
#(
  parameter int W     = DMX_W,
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_dest,
  output logic             in_ready,
  input  logic             mode,
  input  logic             clr_cnt,
  output logic             dmx_sel,
  output logic [W-1:0]     dmx_data,
  output logic             out_valid_0,
  output logic             out_valid_1,
  input  logic             out_ready_0,
  input  logic             out_ready_1,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1,
  output logic             busy
);

  localparam logic [7:0] BURST_L = 8'(BURST);

  state_t     state;
  logic       rr_ptr;
  logic [7:0] burst_cnt;

  logic cur_ready;
  logic deliver;
  logic accept;
  logic next_dest;

  // Only the currently selected consumer's ready matters; the other is ignored.
  assign cur_ready = dmx_sel ? out_ready_1 : out_ready_0;
  assign deliver   = (state == ST_FULL) && cur_ready;
  // A delivering cycle frees the register, so a new word can pass straight in.
  assign in_ready  = (state == ST_EMPTY) || cur_ready;
  assign accept    = in_valid && in_ready;
  // Destination is fixed at accept time; later mode changes do not affect a held word.
  assign next_dest = (mode == MODE_TAG) ? in_dest : rr_ptr;

  // Occupancy FSM with registered demux drive, valids and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      dmx_sel     <= 1'b0;
      dmx_data    <= '0;
      out_valid_0 <= 1'b0;
      out_valid_1 <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state       <= ST_FULL;
            dmx_sel     <= next_dest;
            dmx_data    <= in_data;
            out_valid_0 <= ~next_dest;
            out_valid_1 <= next_dest;
            busy        <= 1'b1;
          end
        end
        ST_FULL: begin
          if (accept) begin
            // Pass-through: the held word leaves while the new one is loaded.
            dmx_sel     <= next_dest;
            dmx_data    <= in_data;
            out_valid_0 <= ~next_dest;
            out_valid_1 <= next_dest;
          end else if (deliver) begin
            state       <= ST_EMPTY;
            out_valid_0 <= 1'b0;
            out_valid_1 <= 1'b0;
            busy        <= 1'b0;
          end
        end
      endcase
    end
  end

  // Round-robin burst tracking, advanced only by accepts made in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else if (accept && (mode == MODE_RR)) begin
      if (burst_cnt == BURST_L - 8'd1) begin
        burst_cnt <= '0;
        rr_ptr    <= ~rr_ptr;
      end else begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid_0 && out_ready_0),
    .clr   (clr_cnt),
    .cnt   (cnt_0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid_1 && out_ready_1),
    .clr   (clr_cnt),
    .cnt   (cnt_1)
  );

endmodule
